// File: rtl/alu_pkg.sv
// Shared types and constants for the nibble-serial 74181 ALU front end.
package alu_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Common function selects; XOR and AND assume logic mode (m=1).
    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_XOR = 4'b0110;
    localparam logic [3:0] S_AND = 4'b1011;

endpackage

// File: rtl/alu_nibble_slice.sv
// Combinational 4-bit 74181 slice: active-high data, active-low carry in/out
// and active-low group propagate/generate.
module alu_nibble_slice
    import alu_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn_n,
    output logic [NIB_W-1:0] f,
    output logic             cn4_n,
    output logic             p_n,
    output logic             g_n
);

    logic [NIB_W-1:0] p;
    logic [NIB_W-1:0] g;
    logic [NIB_W:0]   c;

    always_comb begin
        // p and g are the inverted per-bit propagate and generate terms.
        p = ~(a | (b & {NIB_W{s[0]}}) | (~b & {NIB_W{s[1]}}));
        g = ~((a & ~b & {NIB_W{s[2]}}) | (a & b & {NIB_W{s[3]}}));

        c    = '0;
        c[0] = ~cn_n;
        for (int i = 0; i < NIB_W; i++) begin
            c[i+1] = ~g[i] | (~p[i] & c[i]);
        end

        // Logic mode holds the carry term at its inactive level, which
        // reaches F as a constant 1 in the XOR.
        f     = p ^ g ^ (c[NIB_W-1:0] | {NIB_W{m}});
        cn4_n = ~c[NIB_W];

        p_n = |p;
        g_n = ~(~g[3]
               | (~p[3] & ~g[2])
               | (~p[3] & ~p[2] & ~g[1])
               | (~p[3] & ~p[2] & ~p[1] & ~g[0]));
    end

endmodule

// File: rtl/alu16_nibble_seq.sv
// Nibble-serial ALU: runs one 74181 slice over NIBBLES cycles, LSB nibble first.
// Optional group propagate/generate outputs are enabled by ALU_GROUP_PG_EN.
module alu16_nibble_seq
    import alu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NIBBLES*NIB_W-1:0] a,
    input  logic [NIBBLES*NIB_W-1:0] b,
    input  logic [3:0]               s,
    input  logic                     m,
    input  logic                     cn_n,
    output logic                     ready,
    output logic                     done,
    output logic [NIBBLES*NIB_W-1:0] f,
    output logic                     co_n,
    output logic                     aeqb
`ifdef ALU_GROUP_PG_EN
    ,
    output logic                     grp_p_n,
    output logic                     grp_g_n
`endif
);

    localparam int WIDTH = NIBBLES * NIB_W;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         s_q, s_d;
    logic               m_q, m_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   f_q, f_d;
    logic               co_n_q, co_n_d;
    logic               aeqb_q, aeqb_d;
    logic               done_q, done_d;

    logic [NIB_W-1:0]   slice_f;
    logic               slice_cn4_n;
    logic               slice_p_n;
    logic               slice_g_n;

`ifdef ALU_GROUP_PG_EN
    logic pacc_q, pacc_d;
    logic gacc_q, gacc_d;
    logic grp_p_n_q, grp_p_n_d;
    logic grp_g_n_q, grp_g_n_d;
`else
    logic unused_pg;
    assign unused_pg = slice_p_n ^ slice_g_n;
`endif

    alu_nibble_slice u_slice (
        .a     (a_q[idx_q*NIB_W +: NIB_W]),
        .b     (b_q[idx_q*NIB_W +: NIB_W]),
        .s     (s_q),
        .m     (m_q),
        .cn_n  (carry_q),
        .f     (slice_f),
        .cn4_n (slice_cn4_n),
        .p_n   (slice_p_n),
        .g_n   (slice_g_n)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        m_d     = m_q;
        res_d   = res_q;
        f_d     = f_q;
        co_n_d  = co_n_q;
        aeqb_d  = aeqb_q;
        done_d  = 1'b0;
`ifdef ALU_GROUP_PG_EN
        pacc_d    = pacc_q;
        gacc_d    = gacc_q;
        grp_p_n_d = grp_p_n_q;
        grp_g_n_d = grp_g_n_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    s_d     = s;
                    m_d     = m;
                    carry_d = cn_n;
                    idx_d   = '0;
                    state_d = RUN;
`ifdef ALU_GROUP_PG_EN
                    pacc_d  = 1'b1;
                    gacc_d  = 1'b0;
`endif
                end
            end
            RUN: begin
                res_d[idx_q*NIB_W +: NIB_W] = slice_f;
                carry_d = slice_cn4_n;
                idx_d   = idx_q + 1'b1;
`ifdef ALU_GROUP_PG_EN
                pacc_d  = pacc_q & ~slice_p_n;
                gacc_d  = ~slice_g_n | (~slice_p_n & gacc_q);
`endif
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Visible outputs update only here so they hold across the next run.
                f_d     = res_q;
                co_n_d  = carry_q;
                aeqb_d  = &res_q;
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef ALU_GROUP_PG_EN
                grp_p_n_d = ~pacc_q;
                grp_g_n_d = ~gacc_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            res_q   <= '0;
            f_q     <= '0;
            co_n_q  <= 1'b1;
            aeqb_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_GROUP_PG_EN
            pacc_q    <= 1'b1;
            gacc_q    <= 1'b0;
            grp_p_n_q <= 1'b1;
            grp_g_n_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            m_q     <= m_d;
            res_q   <= res_d;
            f_q     <= f_d;
            co_n_q  <= co_n_d;
            aeqb_q  <= aeqb_d;
            done_q  <= done_d;
`ifdef ALU_GROUP_PG_EN
            pacc_q    <= pacc_d;
            gacc_q    <= gacc_d;
            grp_p_n_q <= grp_p_n_d;
            grp_g_n_q <= grp_g_n_d;
`endif
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign f     = f_q;
    assign co_n  = co_n_q;
    assign aeqb  = aeqb_q;
`ifdef ALU_GROUP_PG_EN
    assign grp_p_n = grp_p_n_q;
    assign grp_g_n = grp_g_n_q;
`endif

endmodule

// File: tb/tb_alu16_nibble_seq.sv
// Scoreboard bench for alu16_nibble_seq: directed cases plus random operations
// against a word-level 74181 model.
module tb_alu16_nibble_seq;

    localparam int W  = 16;
    localparam int EW = W + 5;
    localparam int LATENCY = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [3:0]    s = '0;
    logic          m = 1'b0;
    logic          cn_n = 1'b1;
    logic          ready;
    logic          done;
    logic [W-1:0]  f;
    logic          co_n;
    logic          aeqb;
`ifdef ALU_GROUP_PG_EN
    logic          grp_p_n;
    logic          grp_g_n;
`endif

    // exp word: {f[15:0], co_n, check_co, aeqb, grp_p_n, grp_g_n}
    logic [EW-1:0] exp_q[$];
    int            acc_q[$];
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            n_done = 0;
    logic [EW-1:0] e;
    int            acc;

    alu16_nibble_seq #(.NIBBLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .s       (s),
        .m       (m),
        .cn_n    (cn_n),
        .ready   (ready),
        .done    (done),
        .f       (f),
        .co_n    (co_n),
        .aeqb    (aeqb)
`ifdef ALU_GROUP_PG_EN
        ,
        .grp_p_n (grp_p_n),
        .grp_g_n (grp_g_n)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Word view of the 74181: with P/G the active-high per-bit terms, the
    // arithmetic result is P + G + carry_in, logic mode gives ~(P ^ G).
    function automatic logic [EW-1:0] model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                            input logic [3:0] is, input logic im, input logic icn);
        logic [W-1:0] pw, gw, fw;
        logic [W:0]   sum, gsum;
        pw   = ia | (ib & {W{is[0]}}) | (~ib & {W{is[1]}});
        gw   = (ia & ~ib & {W{is[2]}}) | (ia & ib & {W{is[3]}});
        sum  = {1'b0, pw} + {1'b0, gw} + {{W{1'b0}}, ~icn};
        gsum = {1'b0, pw} + {1'b0, gw};
        fw   = im ? ~(pw ^ gw) : sum[W-1:0];
        return {fw, ~sum[W], ~im, &fw, ~(&pw), ~gsum[W]};
    endfunction

    function automatic logic [EW-1:0] directed(input logic [W-1:0] ef, input logic eco, input logic chk,
                                               input logic eq, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                               input logic [3:0] is, input logic im, input logic icn);
        logic [EW-1:0] mdl;
        mdl = model(ia, ib, is, im, icn);
        return {ef, eco, chk, eq, mdl[1], mdl[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [3:0] is,
                         input logic im, input logic icn, input logic [EW-1:0] ex);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 20 cycles");
            return;
        end
        a = ia; b = ib; s = is; m = im; cn_n = icn;
        start = 1'b1;
        exp_q.push_back(ex);
        @(posedge clk);
        #1 acc_q.push_back(cyc);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); s = 4'($urandom);
        m = 1'($urandom); cn_n = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got %0d pending expected 0 pending", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_done"},  32'(done),  32'd0);
        check({tag, "_f"},     32'(f),     32'd0);
        check({tag, "_co_n"},  32'(co_n),  32'd1);
        check({tag, "_aeqb"},  32'(aeqb),  32'd0);
`ifdef ALU_GROUP_PG_EN
        check({tag, "_grp_p_n"}, 32'(grp_p_n), 32'd1);
        check({tag, "_grp_g_n"}, 32'(grp_g_n), 32'd1);
`endif
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        #1;
        if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 f=0x%0h expected no done", f);
            end else begin
                e   = exp_q.pop_front();
                acc = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
                check("f", 32'(f), 32'(e[EW-1:5]));
                check("aeqb", 32'(aeqb), 32'(e[2]));
                check("latency", 32'(cyc - acc), 32'(LATENCY));
                check("ready_at_done", 32'(ready), 32'd1);
                if (e[3]) check("co_n", 32'(co_n), 32'(e[4]));
`ifdef ALU_GROUP_PG_EN
                check("grp_p_n", 32'(grp_p_n), 32'(e[1]));
                check("grp_g_n", 32'(grp_g_n), 32'(e[0]));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int dn;
        logic [W-1:0] ra, rb;
        logic [3:0]   rs;
        logic         rm, rc;

        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        // Add
        issue(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1,
              directed(16'h2233, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1));
        drain();
        // Wrap
        issue(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1,
              directed(16'h0000, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1));
        drain();
        // Compare equal
        issue(16'hBEEF, 16'hBEEF, 4'b0110, 1'b0, 1'b1,
              directed(16'hFFFF, 1'b1, 1'b1, 1'b1, 16'hBEEF, 16'hBEEF, 4'b0110, 1'b0, 1'b1));
        drain();
        // Subtract
        issue(16'h0005, 16'h0003, 4'b0110, 1'b0, 1'b0,
              directed(16'h0002, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0003, 4'b0110, 1'b0, 1'b0));
        drain();

        // Logic XOR with a stray start mid-RUN
        dn = n_done;
        issue(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1,
              directed(16'h0FF0, 1'b1, 1'b0, 1'b0, 16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1));
        check("ready_in_run", 32'(ready), 32'd0);
        a = 16'h1111; b = 16'h2222; s = 4'b1001; m = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (8) @(negedge clk);
        check("single_done", 32'(n_done - dn), 32'd1);
        check("hold_f", 32'(f), 32'h0FF0);

        // Reset after two nibbles have been processed
        dn = n_done;
        issue(16'h7777, 16'h1111, 4'b1001, 1'b0, 1'b1, model(16'h7777, 16'h1111, 4'b1001, 1'b0, 1'b1));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        @(posedge clk);
        #1 check_reset_vals("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("no_done_after_reset", 32'(n_done - dn), 32'd0);
        issue(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b1,
              directed(16'h0002, 1'b1, 1'b1, 1'b0, 16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b1));
        drain();

        // Group P/G case: all-propagate, no generate
        issue(16'hFFFF, 16'h0000, 4'b1001, 1'b0, 1'b1,
              {16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
        drain();

        // Random operations, issued back to back
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = ((i % 7) == 0) ? ra : W'($urandom);
            rs = 4'($urandom_range(0, 15));
            rm = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            issue(ra, rb, rs, rm, rc, model(ra, rb, rs, rm, rc));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
